pkt_stream_fifo: RTL and testbench

Store-and-forward packet FIFO for the 10G MAC Avalon-ST stream, sitting between a packet source (pcap parser, MAC RX) and a packet sink (pcap writer, MAC TX). It accepts packets without backpressure, buffers each one until its eop word arrives, and then drops errored or overflowing packets whole, so that a truncated packet never reaches the sink. Committed packets are replayed with a parametrised minimum inter-packet gap and per-port statistics. It generalises the fixed 64-bit, fixed-gap stream of the current replay path.

---
 rtl/pkt_stream_pkg.sv | 28 ++
 rtl/pkt_fifo_ram.sv | 40 ++++
 rtl/pkt_stream_fifo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_pkt_stream_fifo.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_stream_pkg.sv
// Shared definitions for the store-and-forward packet FIFO.
// Holds the error-field width, the write-side and output-side state
// encodings, and a saturating add used by the statistics counters.
package pkt_stream_pkg;

   localparam int ERR_W = 6;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_PKT     = 2'd1,
      W_DISCARD = 2'd2
   } wrState_t;

   typedef enum logic [1:0] {
      O_IDLE = 2'd0,
      O_SEND = 2'd1,
      O_GAP  = 2'd2
   } outState_t;

   // Adds a small increment to a 16-bit statistic, sticking at 16'hFFFF
   // rather than wrapping so a long run never reports a tiny count.
   function automatic logic [15:0] satAdd16(input logic [15:0] value, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, value} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port synchronous RAM used as the packet buffer.
// One write port and one read port on the same clock; read data appears
// on the cycle after rdEn_i and holds when rdEn_i is low.
// Ports:
//   clk       - clock
//   wrEn_i    - write strobe
//   wrAddr_i  - write address
//   wrData_i  - write data
//   rdEn_i    - read strobe
//   rdAddr_i  - read address
//   rdData_o  - registered read data
module pkt_fifo_ram #(
   parameter int WIDTH = 74,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             wrEn_i,
   input  logic [AW-1:0]    wrAddr_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic             rdEn_i,
   input  logic [AW-1:0]    rdAddr_i,
   output logic [WIDTH-1:0] rdData_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage array and read register. The read register is only loaded
   // on request so the output side can park a word on the bus while the
   // sink stalls, without a separate holding register.
   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
      if (rdEn_i) begin
         rdData_o <= mem[rdAddr_i];
      end
   end

endmodule

// File: rtl/pkt_stream_fifo.sv
// Store-and-forward packet FIFO for an Avalon-ST stream.
// Packets are buffered until their eop word arrives; errored, overflowing
// or truncated packets are rewound and never reach the sink. Committed
// packets are replayed with a minimum inter-packet gap.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   asi_in_*              - ingress stream (never backpressured)
//   aso_out_*             - egress stream, ready latency 0
//   pause                 - blocks the start of the next egress packet
//   pktcount              - committed packets not yet fully sent (saturating)
//   pkts_in, pkts_dropped - saturating packet statistics
module pkt_stream_fifo
   import pkt_stream_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int EMPTY_W  = $clog2(DATA_W/8),
   parameter int DEPTH    = 512,
   parameter int IPG      = 4,
   parameter bit DROP_ERR = 1'b1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  asi_in_data,
   input  logic               asi_in_valid,
   input  logic               asi_in_sop,
   input  logic               asi_in_eop,
   input  logic [EMPTY_W-1:0] asi_in_empty,
   input  logic [ERR_W-1:0]   asi_in_error,
   output logic               asi_in_ready,
   output logic [DATA_W-1:0]  aso_out_data,
   output logic               aso_out_valid,
   input  logic               aso_out_ready,
   output logic               aso_out_sop,
   output logic               aso_out_eop,
   output logic [EMPTY_W-1:0] aso_out_empty,
   output logic [ERR_W-1:0]   aso_out_error,
   input  logic               pause,
   output logic [7:0]         pktcount,
   output logic [15:0]        pkts_in,
   output logic [15:0]        pkts_dropped
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = AW + 1;
   localparam int ENT_W = DATA_W + 1 + EMPTY_W + ERR_W;
   localparam int GW    = (IPG > 1) ? $clog2(IPG + 1) : 1;

   wrState_t         wrState_q, wrState_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    commitPtr_q, commitPtr_d;
   logic [15:0]      pktsIn_q, pktsIn_d;
   logic [15:0]      pktsDropped_q, pktsDropped_d;
   logic [1:0]       dropInc;
   logic             commitEv;
   logic [PW-1:0]    wrBase;
   logic             baseFull;
   logic             badErr;
   logic             ramWe;
   logic [AW-1:0]    ramWAddr;
   logic [ENT_W-1:0] ramWData;

   outState_t        outState_q, outState_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW-1:0]    rdNext;
   logic             primed_q, primed_d;
   logic             first_q, first_d;
   logic [GW-1:0]    gapCnt_q, gapCnt_d;
   logic             ramRe;
   logic [AW-1:0]    ramRAddr;
   logic [ENT_W-1:0] ramRData;
   logic             eopDec;
   logic             outValid;
   logic             outHs;

   logic [PW-1:0]    pktCnt_q, pktCnt_d;

   logic [DATA_W-1:0]  entData;
   logic               entEop;
   logic [EMPTY_W-1:0] entEmpty;
   logic [ERR_W-1:0]   entErr;

   assign asi_in_ready = 1'b1;

   // Only the eop word carries meaningful empty/error fields, so anything
   // else is stored as zero and the egress side can forward them as-is.
   assign ramWData = {asi_in_data, asi_in_eop,
                      asi_in_eop ? asi_in_empty : {EMPTY_W{1'b0}},
                      asi_in_eop ? asi_in_error : {ERR_W{1'b0}}};

   // Write-side decision logic. A sop always restarts at the commit point,
   // which is how a partial packet with a missing eop gets discarded, and a
   // dropped packet is undone simply by rewinding wrPtr to commitPtr. The
   // full test uses the base address the word would land on, so a restart
   // sees the space freed by the rewind in the same cycle.
   always_comb begin
      wrState_d   = wrState_q;
      wrPtr_d     = wrPtr_q;
      commitPtr_d = commitPtr_q;
      dropInc     = 2'd0;
      commitEv    = 1'b0;
      ramWe       = 1'b0;
      wrBase      = asi_in_sop ? commitPtr_q : wrPtr_q;
      ramWAddr    = wrBase[AW-1:0];
      baseFull    = ((wrBase - rdPtr_q) == PW'(DEPTH));
      badErr      = DROP_ERR && (asi_in_error != '0);
      if (asi_in_valid) begin
         if (asi_in_sop && (wrState_q == W_PKT)) begin
            dropInc = dropInc + 2'd1;
         end
         if (asi_in_sop || (wrState_q == W_PKT)) begin
            if (baseFull) begin
               wrPtr_d = commitPtr_q;
               if (asi_in_eop) begin
                  dropInc   = dropInc + 2'd1;
                  wrState_d = W_IDLE;
               end else begin
                  wrState_d = W_DISCARD;
               end
            end else begin
               ramWe = 1'b1;
               if (asi_in_eop) begin
                  wrState_d = W_IDLE;
                  if (badErr) begin
                     wrPtr_d = commitPtr_q;
                     dropInc = dropInc + 2'd1;
                  end else begin
                     wrPtr_d     = wrBase + PW'(1);
                     commitPtr_d = wrBase + PW'(1);
                     commitEv    = 1'b1;
                  end
               end else begin
                  wrPtr_d   = wrBase + PW'(1);
                  wrState_d = W_PKT;
               end
            end
         end else if ((wrState_q == W_DISCARD) && asi_in_eop) begin
            dropInc   = dropInc + 2'd1;
            wrState_d = W_IDLE;
         end
      end
      pktsIn_d      = commitEv ? satAdd16(pktsIn_q, 2'd1) : pktsIn_q;
      pktsDropped_d = satAdd16(pktsDropped_q, dropInc);
   end

   assign entData  = ramRData[ENT_W-1 -: DATA_W];
   assign entEop   = ramRData[ERR_W + EMPTY_W];
   assign entEmpty = ramRData[ERR_W +: EMPTY_W];
   assign entErr   = ramRData[ERR_W-1:0];

   assign outValid = (outState_q == O_SEND) && primed_q;
   assign outHs    = outValid && aso_out_ready;
   assign rdNext   = rdPtr_q + PW'(1);

   // Output-side sequencing. Starting a packet reads its first word, which
   // then needs one priming cycle before it is shown as valid. rdPtr_q is
   // the word currently on the bus and only advances on a handshake, so
   // the slot it frees is seen by the write side on the following cycle.
   // The next word is read on the handshake itself, giving one word per
   // cycle while ready stays high.
   always_comb begin
      outState_d = outState_q;
      rdPtr_d    = rdPtr_q;
      primed_d   = primed_q;
      first_d    = first_q;
      gapCnt_d   = gapCnt_q;
      ramRe      = 1'b0;
      ramRAddr   = rdPtr_q[AW-1:0];
      eopDec     = 1'b0;
      case (outState_q)
         O_IDLE: begin
            if ((pktCnt_q != '0) && !pause) begin
               ramRe      = 1'b1;
               outState_d = O_SEND;
               primed_d   = 1'b0;
               first_d    = 1'b1;
            end
         end
         O_SEND: begin
            if (!primed_q) begin
               primed_d = 1'b1;
            end else if (outHs) begin
               rdPtr_d = rdNext;
               first_d = 1'b0;
               if (entEop) begin
                  eopDec   = 1'b1;
                  primed_d = 1'b0;
                  gapCnt_d = '0;
                  outState_d = (IPG > 0) ? O_GAP : O_IDLE;
               end else begin
                  ramRe    = 1'b1;
                  ramRAddr = rdNext[AW-1:0];
               end
            end
         end
         O_GAP: begin
            if (gapCnt_q == GW'(IPG - 1)) begin
               outState_d = O_IDLE;
            end else begin
               gapCnt_d = gapCnt_q + GW'(1);
            end
         end
         default: begin
            outState_d = O_IDLE;
         end
      endcase
   end

   // Pending-packet count shared by both sides; a commit and an eop
   // handshake in the same cycle cancel out.
   always_comb begin
      pktCnt_d = pktCnt_q;
      case ({commitEv, eopDec})
         2'b10:   pktCnt_d = pktCnt_q + PW'(1);
         2'b01:   pktCnt_d = pktCnt_q - PW'(1);
         default: pktCnt_d = pktCnt_q;
      endcase
   end

   // All state registers. Reset discards any buffered packets by clearing
   // every pointer together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrState_q     <= W_IDLE;
         wrPtr_q       <= '0;
         commitPtr_q   <= '0;
         pktsIn_q      <= '0;
         pktsDropped_q <= '0;
         outState_q    <= O_IDLE;
         rdPtr_q       <= '0;
         primed_q      <= 1'b0;
         first_q       <= 1'b0;
         gapCnt_q      <= '0;
         pktCnt_q      <= '0;
      end else begin
         wrState_q     <= wrState_d;
         wrPtr_q       <= wrPtr_d;
         commitPtr_q   <= commitPtr_d;
         pktsIn_q      <= pktsIn_d;
         pktsDropped_q <= pktsDropped_d;
         outState_q    <= outState_d;
         rdPtr_q       <= rdPtr_d;
         primed_q      <= primed_d;
         first_q       <= first_d;
         gapCnt_q      <= gapCnt_d;
         pktCnt_q      <= pktCnt_d;
      end
   end

   pkt_fifo_ram #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk      (clk),
      .wrEn_i   (ramWe),
      .wrAddr_i (ramWAddr),
      .wrData_i (ramWData),
      .rdEn_i   (ramRe),
      .rdAddr_i (ramRAddr),
      .rdData_o (ramRData)
   );

   // The RAM read register is not reset, so every egress field is gated by
   // valid to keep the bus at zero when nothing is being presented.
   assign aso_out_valid = outValid;
   assign aso_out_data  = outValid ? entData : '0;
   assign aso_out_sop   = outValid && first_q;
   assign aso_out_eop   = outValid && entEop;
   assign aso_out_empty = (outValid && entEop) ? entEmpty : '0;
   assign aso_out_error = (outValid && entEop && !DROP_ERR) ? entErr : '0;

   assign pktcount     = (32'(pktCnt_q) > 32'd255) ? 8'hFF : 8'(pktCnt_q);
   assign pkts_in      = pktsIn_q;
   assign pkts_dropped = pktsDropped_q;

endmodule

// File: tb/tb_pkt_stream_fifo.sv
module tb_pkt_stream_fifo;

   localparam int DATA_W  = 64;
   localparam int EMPTY_W = 3;
   localparam int DEPTH   = 16;
   localparam int IPG     = 4;

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic [5:0]  err;
      int          cycle;
   } outWord_t;

   typedef struct {
      int         id;
      int         len;
      logic [2:0] empty;
      logic [5:0] err;
      bit         kept;
   } pktVec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] inData = '0;
   logic        inValid = 1'b0;
   logic        inSop = 1'b0;
   logic        inEop = 1'b0;
   logic [2:0]  inEmpty = '0;
   logic [5:0]  inError = '0;
   logic        inReady;
   logic [63:0] outData;
   logic        outValid;
   logic        outReady = 1'b0;
   logic        outSop;
   logic        outEop;
   logic [2:0]  outEmpty;
   logic [5:0]  outError;
   logic        pause = 1'b0;
   logic [7:0]  pktcount;
   logic [15:0] pktsIn;
   logic [15:0] pktsDropped;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int expIn = 0;
   int expDropped = 0;
   outWord_t outQ[$];

   always #5 clk = ~clk;

   pkt_stream_fifo #(
      .DATA_W   (DATA_W),
      .EMPTY_W  (EMPTY_W),
      .DEPTH    (DEPTH),
      .IPG      (IPG),
      .DROP_ERR (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .asi_in_data   (inData),
      .asi_in_valid  (inValid),
      .asi_in_sop    (inSop),
      .asi_in_eop    (inEop),
      .asi_in_empty  (inEmpty),
      .asi_in_error  (inError),
      .asi_in_ready  (inReady),
      .aso_out_data  (outData),
      .aso_out_valid (outValid),
      .aso_out_ready (outReady),
      .aso_out_sop   (outSop),
      .aso_out_eop   (outEop),
      .aso_out_empty (outEmpty),
      .aso_out_error (outError),
      .pause         (pause),
      .pktcount      (pktcount),
      .pkts_in       (pktsIn),
      .pkts_dropped  (pktsDropped)
   );

   function automatic logic [63:0] mkData(input int id, input int idx);
      return {8'(id), 8'(idx), 16'hBEEF, 8'(id), 8'(idx), 16'h5A5A};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // Drives one ingress word; it is accepted on the following rising edge.
   task automatic applyStimulus(input logic sop, input logic eop, input logic [63:0] data,
                                input logic [2:0] empty, input logic [5:0] err);
      @(posedge clk);
      #1;
      inValid = 1'b1;
      inSop   = sop;
      inEop   = eop;
      inData  = data;
      inEmpty = empty;
      inError = err;
   endtask

   task automatic idleIn();
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inSop   = 1'b0;
      inEop   = 1'b0;
      inError = '0;
   endtask

   task automatic sendPacket(input int id, input int len, input logic [2:0] empty, input logic [5:0] err);
      for (int i = 0; i < len; i++) begin
         applyStimulus(i == 0, i == len - 1, mkData(id, i),
                       (i == len - 1) ? empty : 3'd0, (i == len - 1) ? err : 6'd0);
      end
      idleIn();
   endtask

   task automatic waitWords(input string name, input int n, input int limit);
      for (int c = 0; c < limit && outQ.size() < n; c++) begin
         @(negedge clk);
      end
      if (outQ.size() < n) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout: got %0d words, required %0d", name, outQ.size(), n);
      end
   endtask

   task automatic waitValid(input string name, input int limit);
      for (int c = 0; c < limit && !outValid; c++) begin
         @(negedge clk);
      end
      checkOutput({name, "_valid_seen"}, 64'(outValid), 64'd1);
   endtask

   task automatic checkPacket(input string name, input int id, input int len, input logic [2:0] empty,
                              output int sopCycle, output int eopCycle);
      outWord_t w;
      sopCycle = -1;
      eopCycle = -1;
      for (int i = 0; i < len; i++) begin
         if (outQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_missing: word %0d absent, required %0d words", name, i, len);
            return;
         end
         w = outQ.pop_front();
         checkOutput({name, "_data"}, w.data, mkData(id, i));
         checkOutput({name, "_sop"}, 64'(w.sop), 64'(i == 0));
         checkOutput({name, "_eop"}, 64'(w.eop), 64'(i == len - 1));
         checkOutput({name, "_empty"}, 64'(w.empty), (i == len - 1) ? 64'(empty) : 64'd0);
         checkOutput({name, "_error"}, 64'(w.err), 64'd0);
         if (i == 0) sopCycle = w.cycle;
         if (i == len - 1) eopCycle = w.cycle;
      end
   endtask

   task automatic checkStats(input string name);
      checkOutput({name, "_pkts_in"}, 64'(pktsIn), 64'(expIn));
      checkOutput({name, "_pkts_dropped"}, 64'(pktsDropped), 64'(expDropped));
   endtask

   // Egress monitor: records handshaked words and verifies that a stalled
   // word stays on the bus unchanged until it is accepted.
   initial begin : monitor
      logic        prevStall;
      logic [63:0] prevData;
      logic        prevSop;
      logic        prevEop;
      outWord_t    w;
      prevStall = 1'b0;
      prevData  = '0;
      prevSop   = 1'b0;
      prevEop   = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (reset) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               checks++;
               if (!outValid || outData !== prevData || outSop !== prevSop || outEop !== prevEop) begin
                  failures++;
                  $display("[TB] FAIL hold_stable: got valid=%0b data=%h, required valid=1 data=%h",
                           outValid, outData, prevData);
               end
            end
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevSop   = outSop;
            prevEop   = outEop;
            if (outValid && outReady) begin
               w.data  = outData;
               w.sop   = outSop;
               w.eop   = outEop;
               w.empty = outEmpty;
               w.err   = outError;
               w.cycle = cycle;
               outQ.push_back(w);
            end
         end
      end
   end

   initial begin : main
      pktVec_t vecs[6];
      int sopCyc[6];
      int eopCyc[6];
      int totalWords;
      int gap;
      int sc;
      int ec;

      vecs[0] = '{id: 32, len: 3, empty: 3'd0, err: 6'h00, kept: 1'b1};
      vecs[1] = '{id: 33, len: 3, empty: 3'd2, err: 6'h01, kept: 1'b0};
      vecs[2] = '{id: 34, len: 3, empty: 3'd5, err: 6'h00, kept: 1'b1};
      vecs[3] = '{id: 35, len: 1, empty: 3'd7, err: 6'h00, kept: 1'b1};
      vecs[4] = '{id: 36, len: 5, empty: 3'd3, err: 6'h20, kept: 1'b0};
      vecs[5] = '{id: 37, len: 2, empty: 3'd1, err: 6'h00, kept: 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_out_sop", 64'(outSop), 64'd0);
      checkOutput("rst_out_data", outData, 64'd0);
      checkOutput("rst_pktcount", 64'(pktcount), 64'd0);
      checkStats("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Commit latency: eop accepted at edge t, sop valid after edge t+2
      $display("[TB] commit latency");
      sendPacket(16, 1, 3'd4, 6'h00);
      expIn++;
      @(negedge clk);
      checkOutput("lat_valid_t0", 64'(outValid), 64'd0);
      checkOutput("lat_pktcount", 64'(pktcount), 64'd1);
      @(negedge clk);
      checkOutput("lat_valid_t1", 64'(outValid), 64'd0);
      @(negedge clk);
      checkOutput("lat_valid_t2", 64'(outValid), 64'd1);
      checkOutput("lat_sop_t2", 64'(outSop), 64'd1);
      checkOutput("lat_data_t2", outData, mkData(16, 0));
      @(posedge clk);
      #1;
      outReady = 1'b1;
      waitWords("lat", 1, 20);
      checkPacket("lat_pkt", 16, 1, 3'd4, sc, ec);
      repeat (3) @(negedge clk);
      checkOutput("lat_pktcount_after", 64'(pktcount), 64'd0);

      // Table of packets: kept ones must appear in order, errored ones vanish
      $display("[TB] packet table");
      totalWords = 0;
      for (int i = 0; i < 6; i++) begin
         sendPacket(vecs[i].id, vecs[i].len, vecs[i].empty, vecs[i].err);
         if (vecs[i].kept) begin
            expIn++;
            totalWords += vecs[i].len;
         end else begin
            expDropped++;
         end
      end
      waitWords("table", totalWords, 300);
      for (int i = 0; i < 6; i++) begin
         sopCyc[i] = -1;
         eopCyc[i] = -1;
         if (vecs[i].kept) begin
            checkPacket($sformatf("table_pkt%0d", i), vecs[i].id, vecs[i].len, vecs[i].empty, sc, ec);
            sopCyc[i] = sc;
            eopCyc[i] = ec;
         end
      end
      gap = sopCyc[2] - eopCyc[0] - 1;
      checks++;
      if (gap < IPG || gap > IPG + 2) begin
         failures++;
         $display("[TB] FAIL table_gap: got %0d idle cycles, required %0d..%0d", gap, IPG, IPG + 2);
      end
      repeat (10) @(negedge clk);
      checkStats("table");
      checkOutput("table_pktcount", 64'(pktcount), 64'd0);

      // Backpressure: ready toggling 1010 over a 5-word packet
      $display("[TB] backpressure");
      @(posedge clk);
      #1;
      outReady = 1'b0;
      sendPacket(48, 5, 3'd3, 6'h00);
      expIn++;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         outReady = (i % 2 == 0);
      end
      @(posedge clk);
      #1;
      outReady = 1'b1;
      waitWords("bp", 5, 50);
      checkPacket("bp_pkt", 48, 5, 3'd3, sc, ec);
      repeat (10) @(negedge clk);

      // Overflow: 8-word packet kept, 10-word packet dropped while stalled
      $display("[TB] overflow");
      @(posedge clk);
      #1;
      outReady = 1'b0;
      sendPacket(64, 8, 3'd0, 6'h00);
      sendPacket(65, 10, 3'd2, 6'h00);
      expIn++;
      expDropped++;
      @(negedge clk);
      checkStats("ovf");
      checkOutput("ovf_pktcount", 64'(pktcount), 64'd1);
      @(posedge clk);
      #1;
      outReady = 1'b1;
      waitWords("ovf", 8, 60);
      checkPacket("ovf_pkt8", 64, 8, 3'd0, sc, ec);
      repeat (15) @(negedge clk);
      checkOutput("ovf_no_extra", 64'(outQ.size()), 64'd0);
      sendPacket(66, 4, 3'd6, 6'h00);
      expIn++;
      waitWords("ovf_after", 4, 40);
      checkPacket("ovf_pkt4", 66, 4, 3'd6, sc, ec);
      repeat (10) @(negedge clk);

      // Stray word, then a packet missing its eop, then a one-word packet
      $display("[TB] missing eop");
      applyStimulus(1'b0, 1'b0, mkData(80, 9), 3'd0, 6'h00);
      applyStimulus(1'b1, 1'b0, mkData(81, 0), 3'd0, 6'h00);
      applyStimulus(1'b0, 1'b0, mkData(81, 1), 3'd0, 6'h00);
      applyStimulus(1'b0, 1'b0, mkData(81, 2), 3'd0, 6'h00);
      sendPacket(82, 1, 3'd5, 6'h00);
      expIn++;
      expDropped++;
      waitWords("meop", 1, 30);
      checkPacket("meop_pkt", 82, 1, 3'd5, sc, ec);
      repeat (12) @(negedge clk);
      checkStats("meop");
      checkOutput("meop_no_extra", 64'(outQ.size()), 64'd0);

      // Pause blocks the next start only
      $display("[TB] pause");
      @(posedge clk);
      #1;
      pause = 1'b1;
      sendPacket(96, 2, 3'd1, 6'h00);
      expIn++;
      repeat (8) @(negedge clk);
      checkOutput("pause_valid", 64'(outValid), 64'd0);
      checkOutput("pause_pktcount", 64'(pktcount), 64'd1);
      @(posedge clk);
      #1;
      pause = 1'b0;
      waitWords("pause", 2, 20);
      checkPacket("pause_pkt", 96, 2, 3'd1, sc, ec);
      repeat (10) @(negedge clk);

      // Reset during word 2 of a packet in flight
      $display("[TB] reset mid-packet");
      @(posedge clk);
      #1;
      outReady = 1'b0;
      sendPacket(112, 5, 3'd2, 6'h00);
      waitValid("rstmid", 20);
      @(posedge clk);
      #1;
      outReady = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      outReady = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_word2", outData, mkData(112, 2));
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rstmid_valid", 64'(outValid), 64'd0);
      checkOutput("rstmid_pktcount", 64'(pktcount), 64'd0);
      expIn = 0;
      expDropped = 0;
      checkStats("rstmid");
      outQ.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      outReady = 1'b1;
      sendPacket(113, 4, 3'd6, 6'h00);
      expIn++;
      waitWords("rstmid_after", 4, 30);
      checkPacket("rstmid_pkt", 113, 4, 3'd6, sc, ec);
      checkStats("rstmid_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
